trap_controller: RTL

Machine-mode trap sequencer for the TCORE RV32IMC pipeline; it consumes the exception type, PC and target reported by the execution stage and turns them into pipeline flush, drain and fetch-redirect actions. It owns `mepc`, `mcause`, `mtval`, `mtvec` and the `mstatus` MIE/MPIE bits, handles `MRET` returns, and sits between stage 3 and the fetch/hazard logic.

---
 rtl/trap_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap sequencer for the TCORE pipeline.
// Owns mepc/mcause/mtval/mtvec and mstatus MIE/MPIE; drives flush/drain/redirect.

typedef enum logic [2:0] {
  NO_EXCEPTION        = 3'd0,
  INSTR_MISALIGNED    = 3'd1,
  ILLEGAL_INSTRUCTION = 3'd2,
  BREAKPOINT          = 3'd3,
  LOAD_MISALIGNED     = 3'd4,
  STORE_MISALIGNED    = 3'd5,
  ECALL               = 3'd6
} exc_type_e;

module trap_controller #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  input  exc_type_e       ex_exc_type_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_tval_i,
  input  logic            ex_mret_i,
  input  logic            alu_stall_i,
  input  logic            mem_busy_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_idx_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_hit_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            trap_busy_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    REDIRECT,
    RET
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [XLEN-1:0] mtvec_q;
  logic            mie_q;
  logic            mpie_q;

  logic            trap_take;
  logic            mret_take;
  logic            csr_wr;
  logic            drain_ok;
  logic [4:0]      cause;

  // Decode which IDLE-state action wins this cycle.
  always_comb begin
    trap_take = (state_q == IDLE) && ex_valid_i &&
                (ex_exc_type_i != NO_EXCEPTION);
    mret_take = (state_q == IDLE) && ex_valid_i &&
                ex_mret_i && !trap_take;
    csr_wr    = (state_q == IDLE) && csr_we_i &&
                !trap_take && !mret_take;
    drain_ok  = !alu_stall_i && !mem_busy_i;
  end

  // Exception type to mcause code; interrupts never occur.
  always_comb begin
    cause = 5'd0;
    unique case (1'b1)
      ex_exc_type_i == ILLEGAL_INSTRUCTION: cause = 5'd2;
      ex_exc_type_i == BREAKPOINT:          cause = 5'd3;
      ex_exc_type_i == LOAD_MISALIGNED:     cause = 5'd4;
      ex_exc_type_i == STORE_MISALIGNED:    cause = 5'd6;
      ex_exc_type_i == ECALL:               cause = 5'd11;
      default:                              cause = 5'd0;
    endcase
  end

  // CSR read mux over the registered state.
  always_comb begin
    csr_rdata_o = '0;
    csr_hit_o   = 1'b1;
    case (csr_idx_i)
      CSR_MSTATUS: begin
        csr_rdata_o[12:11] = 2'b11;
        csr_rdata_o[7]     = mpie_q;
        csr_rdata_o[3]     = mie_q;
      end
      CSR_MTVEC:  csr_rdata_o = mtvec_q;
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      CSR_MTVAL:  csr_rdata_o = mtval_q;
      default:    csr_hit_o   = 1'b0;
    endcase
  end

  assign trap_busy_o = (state_q != IDLE);

  // Trap FSM, CSR state and registered pipeline controls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mtvec_q       <= MTVEC_RESET;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      flush_o       <= 1'b0;
      stall_o       <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      flush_o       <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      case (state_q)
        IDLE: begin
          stall_o <= 1'b0;
          if (trap_take) begin
            mepc_q   <= {ex_pc_i[XLEN-1:1], 1'b0};
            mcause_q <= {{(XLEN-5){1'b0}}, cause};
            mtval_q  <= ex_tval_i;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
            flush_o  <= 1'b1;
            stall_o  <= 1'b1;
            state_q  <= DRAIN;
          end else if (mret_take) begin
            mie_q         <= mpie_q;
            mpie_q        <= 1'b1;
            flush_o       <= 1'b1;
            redirect_o    <= 1'b1;
            redirect_pc_o <= mepc_q;
            state_q       <= RET;
          end else if (csr_wr) begin
            case (csr_idx_i)
              CSR_MSTATUS: begin
                mie_q  <= csr_wdata_i[3];
                mpie_q <= csr_wdata_i[7];
              end
              CSR_MTVEC:  mtvec_q  <= {csr_wdata_i[XLEN-1:2], 2'b00};
              CSR_MEPC:   mepc_q   <= {csr_wdata_i[XLEN-1:1], 1'b0};
              CSR_MCAUSE: mcause_q <= csr_wdata_i;
              CSR_MTVAL:  mtval_q  <= csr_wdata_i;
              default: ;
            endcase
          end
        end
        DRAIN: begin
          stall_o <= 1'b1;
          if (drain_ok) begin
            redirect_o    <= 1'b1;
            redirect_pc_o <= {mtvec_q[XLEN-1:2], 2'b00};
            state_q       <= REDIRECT;
          end
        end
        REDIRECT: begin
          stall_o <= 1'b0;
          state_q <= IDLE;
        end
        RET: begin
          stall_o <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          stall_o <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
